riscv_v_alu_wb_queue: RTL and testbench
=======================================

// Module: riscv_v_alu_wb_queue
// PURPOSE
//  Writeback queue directly downstream of the vector arithmetic ALU. Captures result, zf/of/cf plus
//  decoder sideband (vd, osize) on a valid/ready handshake; buffers up to DEPTH entries in order;
//  presents them to the vector register file write port. Keeps a sticky saturation flag (OR of
//  of bits retired to the VRF) for the vxsat CSR.
// PARAMETERS
//  DEPTH    4   queue entries; power of two, >=2
//  VD_W     5   destination vector register index width
// PORTS
//  clk          in   1                     clock, all state on posedge
//  rst_n        in   1                     async active-low reset
//  flush        in   1                     sync: drop all queued entries (pipeline kill)
//  alu_valid    in   1                     ALU result + sideband valid this cycle
//  alu_ready    out  1                     queue can accept (registered, = !full)
//  alu_result   in   $bits(riscv_v_wb_data_t)  ALU result
//  alu_zf       in   $bits(riscv_v_zf_t)   per-element zero flags
//  alu_of       in   $bits(riscv_v_of_t)   per-element overflow flags
//  alu_cf       in   $bits(riscv_v_cf_t)   per-element carry flags
//  alu_vd       in   VD_W                  destination register
//  alu_osize    in   $bits(riscv_v_osize_e) element size of result
//  wb_valid     out  1                     head entry valid to VRF
//  wb_ready     in   1                     VRF accepts head entry
//  wb_data      out  $bits(riscv_v_wb_data_t)  head result
//  wb_zf/wb_of/wb_cf out flag widths as above  head flags
//  wb_vd        out  VD_W                  head destination
//  wb_osize     out  $bits(riscv_v_osize_e) head element size
//  sat_sticky   out  1                     OR of of-bits of all retired entries since clear
//  sat_clr      in   1                     clear sat_sticky (CSR write)
//  count        out  $clog2(DEPTH)+1       occupancy
// BEHAVIOUR
//  - Reset: all pointers 0, count=0, wb_valid=0, alu_ready=1, sat_sticky=0, wb_* data outputs 0.
//  - Push when alu_valid&alu_ready; pop when wb_valid&wb_ready. wb_* driven from head storage
//    (no combinational path alu_* -> wb_*); min latency push->wb_valid = 1 cycle.
//  - alu_ready = !full, a registered value: when full, a same-cycle pop does NOT allow a push.
//  - Simultaneous push+pop when 0<count<DEPTH: count unchanged, both pointers advance.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0; full/empty derived from count.
//  - wb_valid = (count!=0); wb_* hold stable while wb_valid&!wb_ready.
//  - alu_valid while !alu_ready: entry dropped; ALU must hold. Pop when empty impossible.
//  - flush: next cycle count=0, pointers=0, wb_valid=0; a push in the flush cycle is discarded;
//    a pop in the flush cycle still counts for sat_sticky (entry was accepted by VRF).
//  - sat_sticky <= (sat_sticky & !sat_clr) | (pop & |wb_of). Retirement wins over clear in the
//    same cycle (sticky ends 1).
//  - Async reset mid-operation discards all entries immediately; no partial writeback.
// STRUCTURE
//  - riscv_v_pkg gains: riscv_v_wb_entry_t packed struct {result, zf, of, cf, vd, osize} and
//    RISCV_V_WB_QUEUE_DEPTH default constant.
//  - One sub-module: riscv_v_sync_fifo #(type T, DEPTH) (storage, pointers, count, flush);
//    this block adds the handshake mapping and sat_sticky logic.
// TESTING
//  1 Reset: rst_n=0 mid-stream with count=3 -> count=0, wb_valid=0, alu_ready=1, sat_sticky=0.
//  2 Fill: wb_ready=0, 4 pushes (vd=1..4) -> count=4, alu_ready=0; 5th alu_valid not accepted;
//    then wb_ready=1 -> vd 1,2,3,4 retired in order, one per cycle.
//  3 Streaming: alu_valid=wb_ready=1 for 20 cycles, results 0..19 -> count stays 1, wb_data
//    sequence 0..19 one cycle behind, exercises pointer wrap 3->0 five times.
//  4 Stall hold: wb_ready low 3 cycles with head result=32'hDEADBEEF -> wb_* unchanged each cycle.
//  5 Saturation: retire entry with of=1 -> sat_sticky=1; sat_clr alone -> 0; sat_clr in same
//    cycle as of=1 retire -> sat_sticky=1.
//  6 Flush: count=2, flush with simultaneous push and pop -> next cycle count=0, wb_valid=0,
//    popped entry's of reflected in sat_sticky, pushed entry never appears on wb_*.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: ALU result/flag widths, element size and the writeback entry
// carried from the ALU to the vector register file.
package riscv_v_pkg;

  localparam int RISCV_V_DATA_W          = 32;
  localparam int RISCV_V_FLAG_W          = 4;
  localparam int RISCV_V_VD_W            = 5;
  localparam int RISCV_V_WB_QUEUE_DEPTH  = 4;

  typedef logic [RISCV_V_DATA_W-1:0] riscv_v_wb_data_t;
  typedef logic [RISCV_V_FLAG_W-1:0] riscv_v_zf_t;
  typedef logic [RISCV_V_FLAG_W-1:0] riscv_v_of_t;
  typedef logic [RISCV_V_FLAG_W-1:0] riscv_v_cf_t;

  typedef enum logic [1:0] {
    OSIZE_E8  = 2'd0,
    OSIZE_E16 = 2'd1,
    OSIZE_E32 = 2'd2,
    OSIZE_E64 = 2'd3
  } riscv_v_osize_e;

  typedef struct packed {
    riscv_v_wb_data_t        result;
    riscv_v_zf_t             zf;
    riscv_v_of_t             of;
    riscv_v_cf_t             cf;
    logic [RISCV_V_VD_W-1:0] vd;
    riscv_v_osize_e          osize;
  } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_sync_fifo.sv
// Generic in-order FIFO with synchronous flush; full/empty are registered from the next count
// so downstream handshake signals come straight from flops.
module riscv_v_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_reg;
  logic [AW:0]    count_next;
  logic           full_reg;
  logic           empty_reg;

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Storage is not reset, so the head is masked to zero whenever nothing is queued
  assign dout  = empty_reg ? T'('0) : mem[rd_ptr];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;

endmodule

// File: rtl/riscv_v_alu_wb_queue.sv
// Writeback queue between the vector ALU and the VRF write port, plus the sticky saturation
// flag feeding vxsat.
module riscv_v_alu_wb_queue
  import riscv_v_pkg::*;
#(
  parameter int DEPTH = RISCV_V_WB_QUEUE_DEPTH,
  parameter int VD_W  = RISCV_V_VD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  riscv_v_wb_data_t        alu_result,
  input  riscv_v_zf_t             alu_zf,
  input  riscv_v_of_t             alu_of,
  input  riscv_v_cf_t             alu_cf,
  input  logic [VD_W-1:0]         alu_vd,
  input  riscv_v_osize_e          alu_osize,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output riscv_v_wb_data_t        wb_data,
  output riscv_v_zf_t             wb_zf,
  output riscv_v_of_t             wb_of,
  output riscv_v_cf_t             wb_cf,
  output logic [VD_W-1:0]         wb_vd,
  output riscv_v_osize_e          wb_osize,
  output logic                    sat_sticky,
  input  logic                    sat_clr,
  output logic [$clog2(DEPTH):0]  count
);

  riscv_v_wb_entry_t in_entry;
  riscv_v_wb_entry_t head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              sat_reg;

  assign in_entry = '{result: alu_result, zf: alu_zf, of: alu_of, cf: alu_cf,
                      vd: alu_vd, osize: alu_osize};

  assign alu_ready = ~full;
  assign wb_valid  = ~empty;
  assign push      = alu_valid & alu_ready;
  assign pop       = wb_valid & wb_ready;

  riscv_v_sync_fifo #(
    .T     (riscv_v_wb_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (in_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign wb_data  = head.result;
  assign wb_zf    = head.zf;
  assign wb_of    = head.of;
  assign wb_cf    = head.cf;
  assign wb_vd    = head.vd;
  assign wb_osize = head.osize;

  // A retirement in the same cycle as a CSR clear leaves the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_reg <= 1'b0;
    else        sat_reg <= (sat_reg & ~sat_clr) | (pop & (|wb_of));
  end

  assign sat_sticky = sat_reg;

endmodule

// File: tb/tb_riscv_v_alu_wb_queue.sv
// Directed bench for the ALU writeback queue: a queue scoreboard predicts every head entry,
// occupancy, handshake and sticky-saturation value.
module tb_riscv_v_alu_wb_queue;
  import riscv_v_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             alu_valid;
  logic             alu_ready;
  riscv_v_wb_data_t alu_result;
  riscv_v_zf_t      alu_zf;
  riscv_v_of_t      alu_of;
  riscv_v_cf_t      alu_cf;
  logic [4:0]       alu_vd;
  riscv_v_osize_e   alu_osize;
  logic             wb_valid;
  logic             wb_ready;
  riscv_v_wb_data_t wb_data;
  riscv_v_zf_t      wb_zf;
  riscv_v_of_t      wb_of;
  riscv_v_cf_t      wb_cf;
  logic [4:0]       wb_vd;
  riscv_v_osize_e   wb_osize;
  logic             sat_sticky;
  logic             sat_clr;
  logic [2:0]       count;

  riscv_v_wb_entry_t sb[$];
  bit                sat_m;
  int                vectors;
  int                miscompares;

  always #5 clk = ~clk;

  riscv_v_alu_wb_queue #(.DEPTH(DEPTH), .VD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_zf(alu_zf), .alu_of(alu_of), .alu_cf(alu_cf), .alu_vd(alu_vd), .alu_osize(alu_osize),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_zf(wb_zf), .wb_of(wb_of),
    .wb_cf(wb_cf), .wb_vd(wb_vd), .wb_osize(wb_osize),
    .sat_sticky(sat_sticky), .sat_clr(sat_clr), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] res, input logic [4:0] vd,
                       input logic [3:0] of);
    alu_valid  = v;
    alu_result = res;
    alu_vd     = vd;
    alu_of     = of;
    alu_zf     = vd[3:0];
    alu_cf     = res[7:4];
    alu_osize  = riscv_v_osize_e'(vd[1:0]);
  endtask

  // Check all outputs against the model, then advance one clock and update the model
  task automatic cyc();
    bit                push;
    bit                pop;
    bit                sat_n;
    riscv_v_wb_entry_t cur;
    riscv_v_wb_entry_t hd;
    chk("count", 64'(count), 64'(sb.size()));
    chk("wb_valid", 64'(wb_valid), 64'(sb.size() != 0));
    chk("alu_ready", 64'(alu_ready), 64'(sb.size() < DEPTH));
    chk("sat_sticky", 64'(sat_sticky), 64'(sat_m));
    hd = (sb.size() != 0) ? sb[0] : '0;
    chk("wb_data", 64'(wb_data), 64'(hd.result));
    chk("wb_vd", 64'(wb_vd), 64'(hd.vd));
    chk("wb_flags", 64'({wb_zf, wb_of, wb_cf}), 64'({hd.zf, hd.of, hd.cf}));
    chk("wb_osize", 64'(wb_osize), 64'(hd.osize));
    cur  = '{result: alu_result, zf: alu_zf, of: alu_of, cf: alu_cf, vd: alu_vd, osize: alu_osize};
    push = alu_valid && (sb.size() < DEPTH);
    pop  = wb_ready && (sb.size() != 0);
    sat_n = (sat_m && !sat_clr) || (pop && (|hd.of));
    if (pop) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (push) sb.push_back(cur);
    @(posedge clk);
    sat_m = sat_n;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    sat_m = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    sat_clr = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    @(negedge clk);
    chk("reset_ready", 64'(alu_ready), 64'd1);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Saturation: retire of=1, clear alone, then clear coinciding with an of=1 retire
    drive(1'b1, 32'h11, 5'd7, 4'b0001); cyc();
    drive(1'b0, 32'h0, 5'd0, 4'h0); wb_ready = 1'b1; cyc();
    wb_ready = 1'b0; cyc();
    chk("sat_set", 64'(sat_sticky), 64'd1);
    sat_clr = 1'b1; cyc();
    sat_clr = 1'b0; cyc();
    chk("sat_cleared", 64'(sat_sticky), 64'd0);
    drive(1'b1, 32'h22, 5'd8, 4'b1000); cyc();
    drive(1'b0, 32'h0, 5'd0, 4'h0); wb_ready = 1'b1; sat_clr = 1'b1; cyc();
    wb_ready = 1'b0; sat_clr = 1'b0; cyc();
    chk("sat_retire_wins", 64'(sat_sticky), 64'd1);

    // Async reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + i, 5'(10 + i), 4'h0); cyc();
    end
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_sat", 64'(sat_sticky), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    sb.delete();
    sat_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Fill to full, offer a 5th entry (also during the first pop), then drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'hA0 + i, 5'(i), 4'h0); cyc();
    end
    drive(1'b1, 32'hA5, 5'd5, 4'h0); cyc();
    chk("full_count", 64'(count), 64'd4);
    wb_ready = 1'b1; cyc();
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < 5; i++) cyc();
    wb_ready = 1'b0;

    // Streaming: one push and one pop per cycle, occupancy stays 1
    wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i), 5'(i), 4'h0); cyc();
    end
    chk("stream_count", 64'(count), 64'd1);
    chk("stream_last", 64'(wb_data), 64'd19);
    drive(1'b0, 32'h0, 5'd0, 4'h0); cyc();

    // Stall hold
    wb_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 5'd31, 4'h0); cyc();
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_data", 64'(wb_data), 64'hDEADBEEF);
      cyc();
    end
    wb_ready = 1'b1; cyc();
    wb_ready = 1'b0;

    // Flush with simultaneous push and pop
    sat_clr = 1'b1; cyc(); sat_clr = 1'b0;
    drive(1'b1, 32'h51, 5'd17, 4'b0010); cyc();
    drive(1'b1, 32'h52, 5'd18, 4'h0); cyc();
    chk("flush_pre_count", 64'(count), 64'd2);
    drive(1'b1, 32'hBAD, 5'd19, 4'h0); flush = 1'b1; wb_ready = 1'b1; cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_sat", 64'(sat_sticky), 64'd1);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
